// File: rtl/ddr_train_pkg.sv
// Shared types and sizing helpers for the DDR4 PHY training controllers.
package ddr_train_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_SETTLE,
    ST_SAMPLE,
    ST_STEP,
    ST_BACK,
    ST_BSETTLE,
    ST_NEXT,
    ST_FIN
  } train_state_e;

  typedef enum logic [1:0] {
    SC_NONE,
    SC_EARLY,
    SC_LATE
  } sample_class_e;

  // Bits needed to hold any value in 0..max_val (never less than one bit).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dqsw_lane_mux.sv
// Selects the active lane's eye-monitor/range inputs and fans the shared
// load/move/clear strobes out to that lane only.
module dqsw_lane_mux
  import ddr_train_pkg::*;
#(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned LW        = 1
) (
  input  logic [LW-1:0]        lane_i,
  input  logic [NUM_LANES-1:0] early_i,
  input  logic [NUM_LANES-1:0] late_i,
  input  logic [NUM_LANES-1:0] oor_i,
  input  logic                 load_en_i,
  input  logic                 move_en_i,
  input  logic                 clr_en_i,
  output sample_class_e        class_o,
  output logic                 oor_o,
  output logic [NUM_LANES-1:0] load_o,
  output logic [NUM_LANES-1:0] move_o,
  output logic [NUM_LANES-1:0] clr_o
);

  logic [NUM_LANES-1:0] sel;
  logic                 early;
  logic                 late;

  always_comb begin
    sel   = '0;
    early = 1'b0;
    late  = 1'b0;
    oor_o = 1'b0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (lane_i == LW'(i)) begin
        sel[i] = 1'b1;
        early  = early_i[i];
        late   = late_i[i];
        oor_o  = oor_i[i];
      end
    end
  end

  always_comb begin
    class_o = SC_NONE;
    if (early && !late) begin
      class_o = SC_EARLY;
    end else if (late && !early) begin
      class_o = SC_LATE;
    end
  end

  assign load_o = sel & {NUM_LANES{load_en_i}};
  assign move_o = sel & {NUM_LANES{move_en_i}};
  assign clr_o  = sel & {NUM_LANES{clr_en_i}};

endmodule

// File: rtl/dqsw_train_sweep_ctrl.sv
// DQSW write-levelling sweep: per lane, step the tap up until an early->late
// transition is seen, back off a few taps, and record the tap or a fail flag.
module dqsw_train_sweep_ctrl
  import ddr_train_pkg::*;
#(
  parameter int unsigned NUM_LANES     = 2,
  parameter int unsigned TAP_W         = 8,
  parameter int unsigned MAX_TAP       = 127,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned BACKOFF       = 4
) (
  input  logic                       FAB_CLK,
  input  logic                       RESET_N,
  input  logic                       START,
  output logic                       BUSY,
  output logic                       DONE,
  output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
  output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
  output logic                       DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0]       EYE_MONITOR_CLEAR_FLAGS,
  input  logic [NUM_LANES-1:0]       EYE_MONITOR_EARLY,
  input  logic [NUM_LANES-1:0]       EYE_MONITOR_LATE,
  input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
  output logic [NUM_LANES*TAP_W-1:0] TAP_RESULT,
  output logic [NUM_LANES-1:0]       LANE_FAIL
);

  localparam int unsigned LW  = cnt_w(NUM_LANES - 1);
  localparam int unsigned TCW = cnt_w(MAX_TAP);
  localparam int unsigned SW  = cnt_w(SETTLE_CYCLES);
  localparam int unsigned BW  = cnt_w(BACKOFF);

  train_state_e               state_q, state_d;
  logic [LW-1:0]              lane_q, lane_d;
  logic [TCW-1:0]             tap_q, tap_d;
  logic                       seen_q, seen_d;
  logic [SW-1:0]              settle_q, settle_d;
  logic [BW-1:0]              rem_q, rem_d;
  logic [NUM_LANES*TAP_W-1:0] res_q, res_d;
  logic [NUM_LANES-1:0]       fail_q, fail_d;

  logic          load_en, move_en, clr_en;
  logic          dir;
  logic          store_res, set_fail;
  logic          edge_hit;
  sample_class_e lane_class;
  logic          lane_oor;

  dqsw_lane_mux #(
    .NUM_LANES (NUM_LANES),
    .LW        (LW)
  ) u_lane_mux (
    .lane_i    (lane_q),
    .early_i   (EYE_MONITOR_EARLY),
    .late_i    (EYE_MONITOR_LATE),
    .oor_i     (DELAY_LINE_OUT_OF_RANGE),
    // Strobes are masked while reset is asserted so an aborted sweep never
    // emits a move/load in the reset cycle itself.
    .load_en_i (load_en && RESET_N),
    .move_en_i (move_en && RESET_N),
    .clr_en_i  (clr_en && RESET_N),
    .class_o   (lane_class),
    .oor_o     (lane_oor),
    .load_o    (DELAY_LINE_LOAD),
    .move_o    (DELAY_LINE_MOVE),
    .clr_o     (EYE_MONITOR_CLEAR_FLAGS)
  );

  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      lane_q   <= '0;
      tap_q    <= '0;
      seen_q   <= 1'b0;
      settle_q <= '0;
      rem_q    <= '0;
      res_q    <= '0;
      fail_q   <= '0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      tap_q    <= tap_d;
      seen_q   <= seen_d;
      settle_q <= settle_d;
      rem_q    <= rem_d;
      res_q    <= res_d;
      fail_q   <= fail_d;
    end
  end

  assign edge_hit = seen_q && (lane_class == SC_LATE);

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    tap_d     = tap_q;
    seen_d    = seen_q;
    settle_d  = settle_q;
    rem_d     = rem_q;
    res_d     = res_q;
    fail_d    = fail_q;
    load_en   = 1'b0;
    move_en   = 1'b0;
    clr_en    = 1'b0;
    dir       = 1'b1;
    store_res = 1'b0;
    set_fail  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          lane_d  = '0;
          res_d   = '0;
          fail_d  = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_en = 1'b1;
        tap_d   = '0;
        seen_d  = 1'b0;
        state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        clr_en   = 1'b1;
        settle_d = SW'(SETTLE_CYCLES - 1);
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      ST_SAMPLE: begin
        if (edge_hit) begin
          // Direction drops here so it is stable a cycle before the first back-off pulse.
          dir     = 1'b0;
          rem_d   = (32'(tap_q) < BACKOFF) ? BW'(tap_q) : BW'(BACKOFF);
          state_d = ST_BACK;
        end else if (lane_oor || (tap_q == TCW'(MAX_TAP))) begin
          set_fail  = 1'b1;
          store_res = 1'b1;
          state_d   = ST_NEXT;
        end else begin
          seen_d  = seen_q || (lane_class == SC_EARLY);
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        move_en = 1'b1;
        tap_d   = tap_q + TCW'(1);
        state_d = ST_CLEAR;
      end
      ST_BACK: begin
        dir = 1'b0;
        if (rem_q != '0) begin
          move_en = 1'b1;
          rem_d   = rem_q - BW'(1);
          if (tap_q != '0) begin
            tap_d = tap_q - TCW'(1);
          end
          state_d = ST_BSETTLE;
        end else begin
          store_res = 1'b1;
          state_d   = ST_NEXT;
        end
      end
      ST_BSETTLE: begin
        dir     = 1'b0;
        state_d = ST_BACK;
      end
      ST_NEXT: begin
        if (lane_q == LW'(NUM_LANES - 1)) begin
          state_d = ST_FIN;
        end else begin
          lane_d  = lane_q + LW'(1);
          state_d = ST_LOAD;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (lane_q == LW'(i)) begin
        if (store_res) begin
          res_d[i*TAP_W +: TAP_W] = TAP_W'(tap_q);
        end
        if (set_fail) begin
          fail_d[i] = 1'b1;
        end
      end
    end
  end

  assign BUSY                 = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign DONE                 = (state_q == ST_FIN);
  assign DELAY_LINE_DIRECTION = dir;
  assign TAP_RESULT           = res_q;
  assign LANE_FAIL            = fail_q;

endmodule

// File: tb/tb_dqsw_train_sweep_ctrl.sv
// Bench for dqsw_train_sweep_ctrl: per-lane delay-line/eye-monitor models
// driven by the DUT strobes, results checked against a tap-scan reference.
module tb_dqsw_train_sweep_ctrl;

  localparam int NL = 2;
  localparam int TW = 8;
  localparam int MT = 127;
  localparam int SC = 8;
  localparam int BO = 4;
  localparam int NEVER = 999;

  logic          FAB_CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          START   = 1'b0;
  logic          BUSY, DONE, DIR;
  logic [NL-1:0] LOAD, MOVE, CLR, EARLY, LATE, OOR;
  logic [NL*TW-1:0] TAP_RESULT;
  logic [NL-1:0]    LANE_FAIL;

  always #5 FAB_CLK = ~FAB_CLK;

  dqsw_train_sweep_ctrl #(
    .NUM_LANES     (NL),
    .TAP_W         (TW),
    .MAX_TAP       (MT),
    .SETTLE_CYCLES (SC),
    .BACKOFF       (BO)
  ) dut (
    .FAB_CLK                 (FAB_CLK),
    .RESET_N                 (RESET_N),
    .START                   (START),
    .BUSY                    (BUSY),
    .DONE                    (DONE),
    .DELAY_LINE_LOAD         (LOAD),
    .DELAY_LINE_MOVE         (MOVE),
    .DELAY_LINE_DIRECTION    (DIR),
    .EYE_MONITOR_CLEAR_FLAGS (CLR),
    .EYE_MONITOR_EARLY       (EARLY),
    .EYE_MONITOR_LATE        (LATE),
    .DELAY_LINE_OUT_OF_RANGE (OOR),
    .TAP_RESULT              (TAP_RESULT),
    .LANE_FAIL               (LANE_FAIL)
  );

  int tests = 0;
  int fails = 0;

  // Lane behaviour: NONE below nb, EARLY in [nb, edge), LATE from edge; out of range from oor.
  int cfg_nb[NL], cfg_edge[NL], cfg_oor[NL];
  int mtap[NL];
  int up_cnt[NL], dn_cnt[NL], ld_cnt[NL];
  int viol, done_cnt, first_load;
  logic prev_dir = 1'b1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] flags(input int lane, input int t);
    if (t < cfg_nb[lane]) return (t % 2 != 0) ? 2'b11 : 2'b00;
    if (t < cfg_edge[lane]) return 2'b01;
    return 2'b10;
  endfunction

  task automatic drive_inputs();
    logic [1:0] f;
    for (int i = 0; i < NL; i++) begin
      f        = flags(i, mtap[i]);
      EARLY[i] = f[0];
      LATE[i]  = f[1];
      OOR[i]   = (mtap[i] >= cfg_oor[i]);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NL; i++) begin
      up_cnt[i] = 0; dn_cnt[i] = 0; ld_cnt[i] = 0;
    end
    viol = 0; done_cnt = 0; first_load = -1;
  endtask

  // Advance one clock, observe this cycle's strobes and update the lane models.
  task automatic cycle();
    @(negedge FAB_CLK);
    START = 1'b0;
    if ($countones(LOAD) > 1 || $countones(MOVE) > 1 || $countones(CLR) > 1) viol++;
    for (int i = 0; i < NL; i++) begin
      if (LOAD[i]) begin
        ld_cnt[i]++;
        mtap[i] = 0;
        if (first_load < 0) first_load = i;
      end
      if (MOVE[i]) begin
        if (DIR) begin
          up_cnt[i]++;
          mtap[i]++;
        end else begin
          dn_cnt[i]++;
          if (prev_dir) viol++;
          mtap[i]--;
        end
      end
    end
    if (DONE) done_cnt++;
    prev_dir = DIR;
    drive_inputs();
  endtask

  function automatic void ref_lane(input int lane, output int res, output bit fail,
                                   output int ups, output int dns, output int cyc);
    bit seen;
    logic [1:0] f;
    int b;
    seen = 0; res = 0; fail = 1; ups = 0; dns = 0; cyc = 0;
    for (int t = 0; t <= MT; t++) begin
      f = flags(lane, t);
      if (seen && f == 2'b10) begin
        b = (t < BO) ? t : BO;
        res = t - b; fail = 0; ups = t; dns = b;
        cyc = (SC + 3) * (t + 1) + 2 * b + 2;
        return;
      end
      if (t >= cfg_oor[lane] || t == MT) begin
        res = t; fail = 1; ups = t; dns = 0;
        cyc = (SC + 3) * (t + 1) + 1;
        return;
      end
      if (f == 2'b01) seen = 1;
    end
  endfunction

  task automatic run(input string tag, input bit spam);
    logic [NL*TW-1:0] exp_res;
    logic [NL-1:0]    exp_fail;
    int exp_up[NL], exp_dn[NL];
    int res, ups, dns, cyc, exp_cyc, n;
    bit fl, got;
    exp_cyc = 1;
    for (int i = 0; i < NL; i++) begin
      ref_lane(i, res, fl, ups, dns, cyc);
      exp_res[i*TW +: TW] = TW'(res);
      exp_fail[i] = fl;
      exp_up[i] = ups;
      exp_dn[i] = dns;
      exp_cyc += cyc;
    end
    clear_counts();
    START = 1'b1;
    cycle();
    n = 1;
    chk({tag, "_busy_after_start"}, BUSY, 1);
    got = 0;
    while (!got && n < 20000) begin
      if (DONE) begin
        got = 1;
      end else begin
        if (spam && $urandom_range(0, 2) == 0) START = 1'b1;
        cycle();
        n++;
      end
    end
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_cycles"}, n, exp_cyc);
    if (spam) START = 1'b1;
    cycle();
    chk({tag, "_busy_after_done"}, BUSY, 0);
    repeat (4) cycle();
    chk({tag, "_tap_result"}, TAP_RESULT, exp_res);
    chk({tag, "_lane_fail"}, LANE_FAIL, exp_fail);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_first_load_lane"}, first_load, 0);
    for (int i = 0; i < NL; i++) begin
      chk($sformatf("%s_up_moves%0d", tag, i), up_cnt[i], exp_up[i]);
      chk($sformatf("%s_down_moves%0d", tag, i), dn_cnt[i], exp_dn[i]);
      chk($sformatf("%s_loads%0d", tag, i), ld_cnt[i], 1);
    end
    chk({tag, "_protocol_violations"}, viol, 0);
  endtask

  task automatic set_cfg(input int nb0, input int e0, input int o0,
                         input int nb1, input int e1, input int o1);
    cfg_nb[0] = nb0; cfg_edge[0] = e0; cfg_oor[0] = o0;
    cfg_nb[1] = nb1; cfg_edge[1] = e1; cfg_oor[1] = o1;
    drive_inputs();
  endtask

  initial begin
    for (int i = 0; i < NL; i++) mtap[i] = 0;
    set_cfg(0, 20, NEVER, 0, 50, NEVER);
    clear_counts();
    RESET_N = 1'b0;
    repeat (3) cycle();
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_strobes", {LOAD, MOVE, CLR}, 0);
    chk("rst_direction", DIR, 1);
    chk("rst_tap_result", TAP_RESULT, 0);
    chk("rst_lane_fail", LANE_FAIL, 0);
    RESET_N = 1'b1;
    cycle();

    run("basic", 0);
    chk("basic_result_literal", TAP_RESULT, {8'd46, 8'd16});

    set_cfg(0, 0, NEVER, 0, 37, NEVER);
    run("always_late", 0);
    chk("always_late_fail0", LANE_FAIL[0], 1);
    chk("always_late_tap0", TAP_RESULT[7:0], 127);

    set_cfg(0, 20, NEVER, 0, NEVER, 30);
    run("oor", 0);
    chk("oor_fail1", LANE_FAIL[1], 1);
    chk("oor_tap1", TAP_RESULT[15:8], 30);

    set_cfg(0, 2, NEVER, 3, 9, NEVER);
    run("small_edge", 0);
    chk("small_edge_down0", dn_cnt[0], 2);
    chk("small_edge_tap0", TAP_RESULT[7:0], 0);

    // Abort during lane 1 settle, then retrain from scratch.
    set_cfg(0, 20, NEVER, 0, 50, NEVER);
    clear_counts();
    START = 1'b1;
    for (int k = 0; k < 5000 && ld_cnt[1] == 0; k++) cycle();
    chk("midrst_reached_lane1", ld_cnt[1], 1);
    repeat (3) cycle();
    RESET_N = 1'b0;
    cycle();
    chk("midrst_busy", BUSY, 0);
    chk("midrst_strobes", {LOAD, MOVE, CLR, DONE}, 0);
    chk("midrst_tap_result", TAP_RESULT, 0);
    chk("midrst_lane_fail", LANE_FAIL, 0);
    RESET_N = 1'b1;
    clear_counts();
    repeat (40) cycle();
    chk("midrst_quiet", up_cnt[0] + up_cnt[1] + dn_cnt[0] + dn_cnt[1] + ld_cnt[0] + ld_cnt[1] + done_cnt, 0);
    run("after_reset", 0);

    run("start_spam", 1);
    chk("start_spam_result_literal", TAP_RESULT, {8'd46, 8'd16});

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NL; i++) begin
        cfg_nb[i]   = $urandom_range(0, 6);
        cfg_edge[i] = ($urandom_range(0, 4) == 0) ? NEVER : cfg_nb[i] + $urandom_range(0, 60);
        cfg_oor[i]  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 90) : NEVER;
      end
      drive_inputs();
      run($sformatf("rand%0d", r), r[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dqsw_train_sweep_ctrl.md
Name: dqsw_train_sweep_ctrl

Overview:
Multi-lane DQSW write-levelling sweep controller for the DDR4 PHY. It drives the dynamic delay-line and eye-monitor controls of NUM_LANES DQSW training IODs, one lane at a time. For each lane it steps the delay tap upward until the eye monitor reports an early-to-late transition, then backs off by BACKOFF taps. It reports a per-lane tap result, a per-lane fail flag and an overall done. It sits between the training sequencer and the per-lane DQSW training IOD wrappers, all in the FAB_CLK domain.

Parameters:
NUM_LANES, 2, number of DQSW training lanes (1..16)
TAP_W, 8, width of the tap counter and result fields
MAX_TAP, 127, last tap tried before a lane is declared failed (MAX_TAP < 2**TAP_W)
SETTLE_CYCLES, 8, FAB_CLK cycles waited after each move/clear before sampling (>=1)
BACKOFF, 4, taps moved back (direction 0) after the edge is found; 0 = no backoff

Ports:
FAB_CLK  in  1  sole clock
RESET_N  in  1  synchronous active-low reset
START  in  1  one-cycle pulse that begins training; ignored unless the FSM is in IDLE
BUSY  out  1  high from the cycle after START until DONE
DONE  out  1  one-cycle pulse when all lanes have finished
DELAY_LINE_LOAD  out  NUM_LANES  one-hot load pulse; resets the lane delay to its static value
DELAY_LINE_MOVE  out  NUM_LANES  one-hot single-tap move pulse
DELAY_LINE_DIRECTION  out  1  shared direction: 1 = increment, 0 = decrement
EYE_MONITOR_CLEAR_FLAGS  out  NUM_LANES  one-hot flag-clear pulse
EYE_MONITOR_EARLY  in  NUM_LANES  per-lane early flag
EYE_MONITOR_LATE  in  NUM_LANES  per-lane late flag
DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  per-lane out-of-range flag
TAP_RESULT  out  NUM_LANES*TAP_W  lane i is at [i*TAP_W +: TAP_W]; final tap after backoff
LANE_FAIL  out  NUM_LANES  lane i found no edge

Behaviour:
- Reset (RESET_N=0 at a FAB_CLK edge):
  - All outputs go to 0 and the FSM goes to IDLE. DELAY_LINE_DIRECTION resets to 1.
  - TAP_RESULT and LANE_FAIL are cleared.
  - Reset mid-sweep aborts immediately. No move/load pulse is emitted in the reset cycle or the cycle after.
- Sample classification for the active lane L: EARLY = (early=1, late=0); LATE = (late=1, early=0); any other combination is NONE.
- FSM states: IDLE, LOAD, CLEAR, SETTLE, SAMPLE, STEP, BACK, BSETTLE, NEXT, FIN.
- IDLE: on START, set L=0, clear all results, BUSY=1, go to LOAD.
- LOAD: pulse DELAY_LINE_LOAD[L] for 1 cycle; tap=0; seen_early=0; go to CLEAR.
- CLEAR: pulse EYE_MONITOR_CLEAR_FLAGS[L] for 1 cycle; go to SETTLE.
- SETTLE: wait exactly SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: one cycle; evaluate in this priority order:
  1. If seen_early and the sample is LATE: edge found at tap; go to BACK.
  2. Else, if DELAY_LINE_OUT_OF_RANGE[L] or tap==MAX_TAP: set LANE_FAIL[L]=1, TAP_RESULT[L]=tap, go to NEXT.
  3. Else: seen_early |= EARLY; go to STEP.
- STEP: DIRECTION=1; pulse DELAY_LINE_MOVE[L]; tap++; go to CLEAR.
- BACK: DIRECTION=0 (set one cycle before and held through the pulse). Issue min(BACKOFF, tap) move pulses, each followed by one idle cycle (BSETTLE). tap decrements per pulse and never wraps below 0. After the last pulse, TAP_RESULT[L]=tap; go to NEXT.
- NEXT: DIRECTION returns to 1. If L==NUM_LANES-1, go to FIN; else L++ and go to LOAD.
- FIN: DONE=1 for 1 cycle, BUSY=0, go to IDLE. Results hold until the next START or reset.
- At most one bit of each one-hot vector is high in any cycle. Only lane L's inputs are sampled; other lanes' inputs are ignored.
- START while busy has no effect. START in the same cycle as FIN's exit is ignored; START is taken in IDLE only.
- Per-lane cycle count with no edge and no backoff: 3 + (SETTLE_CYCLES+3)*MAX_TAP + SETTLE_CYCLES + 1.

Decomposition:
- Shared package ddr_train_pkg holds:
  - the state enum
  - the sample-class enum (EARLY/LATE/NONE)
  - the function computing the tap counter width.
- One natural sub-module: dqsw_lane_mux. It selects lane L's early/late/out-of-range inputs and decodes L into the one-hot load/move/clear vectors (combinational).

Test Plan:
- NUM_LANES=2, SETTLE_CYCLES=8, BACKOFF=4; lane 0 model reports EARLY for taps 0..19 and LATE from tap 20; lane 1 reports EARLY for 0..49 and LATE from 50. Pulse START -> TAP_RESULT = {46, 16}, LANE_FAIL=00, one DONE pulse, and exactly 20 up-moves then 4 down-moves on lane 0.
- Lane 0 reports LATE from tap 0 (never EARLY) -> sweep reaches tap 127, LANE_FAIL[0]=1, TAP_RESULT[0]=127, lane 1 still trains normally.
- Lane 1 asserts DELAY_LINE_OUT_OF_RANGE at tap 30 with no edge -> LANE_FAIL[1]=1, TAP_RESULT[1]=30, DONE asserted.
- Edge at tap 2 with BACKOFF=4 -> exactly 2 down-moves, TAP_RESULT=0, no underflow.
- Assert RESET_N=0 for 1 cycle during lane 1 SETTLE -> all outputs 0 next cycle, BUSY=0, no further move pulses; a new START retrains from lane 0.
- Pulse START repeatedly while BUSY -> ignored; only one DONE; results identical to the single-START run.
